dm_responder: RTL and testbench

- Multi-cycle data-memory responder for the pipeline's M-stage load/store port.
- Accepts one word-wide request at a time over a req/ready handshake and applies byte-enable writes to an internal word array.
- Returns read data after a programmable number of wait states.
- Gives the CPU a realistic slave to stall against, replacing the single-cycle dm.

---
 rtl/dm_responder.sv | 136 +++++++++++++
 tb/tb_dm_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder with byte-enable stores and wait states.
// Optional store trace: define DM_RESPONDER_TRACE_EN.
module dm_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    input  logic [31:0] pc_m,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic        ready_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0]   off_d;
    logic [AW-1:0] idx_d;
    logic          hit_d;
    logic [31:0]   cur_d;
    logic [31:0]   word_d;

    // Decode and byte-merge work purely from the latched request.
    always_comb begin
        off_d  = addr_q - BASE_ADDR;
        idx_d  = off_d[AW+1:2];
        hit_d  = {1'b0, off_d} < LIMIT;
        cur_d  = mem_q[idx_d];
        word_d = cur_d;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                word_d[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        be_q    <= be;
                        wdata_q <= wdata;
                        pc_q    <= pc_m;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= DONE;
                        if (hit_d) begin
                            err_q   <= 1'b0;
                            rdata_q <= we_q ? word_d : cur_d;
                            if (we_q) begin
                                mem_q[idx_d] <= word_d;
                            end
`ifdef DM_RESPONDER_TRACE_EN
                            if (we_q) begin
                                $display("%t @%h: *%h <= %h", $time, pc_q,
                                         addr_q & ~32'h3, word_d);
                            end
`endif
                        end else begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifndef DM_RESPONDER_TRACE_EN
    logic unused_pc;
    assign unused_pc = ^pc_q;
`endif

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: vector table plus latency/reset corners.
// Instance 0 uses WAIT_CYCLES=2, instance 1 uses 0, instance 2 uses 15.
module tb_dm_responder;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [31:0] addr  [3];
    logic [3:0]  be    [3];
    logic [31:0] wdata [3];
    logic [31:0] pc_m  [3];
    logic [2:0]  ready;
    logic [31:0] rdata [3];
    logic [2:0]  err;

    int ncmp;
    int nfail;

    dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]),
        .addr(addr[0]), .be(be[0]), .wdata(wdata[0]), .pc_m(pc_m[0]),
        .ready(ready[0]), .rdata(rdata[0]), .err(err[0])
    );

    dm_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]),
        .addr(addr[1]), .be(be[1]), .wdata(wdata[1]), .pc_m(pc_m[1]),
        .ready(ready[1]), .rdata(rdata[1]), .err(err[1])
    );

    dm_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .reset(reset), .req(req[2]), .we(we[2]),
        .addr(addr[2]), .be(be[2]), .wdata(wdata[2]), .pc_m(pc_m[2]),
        .ready(ready[2]), .rdata(rdata[2]), .err(err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction; lat is the cycle index in which ready is seen
    // (cycle 1 follows the accept edge), -1 on timeout.
    task automatic txn(input int k, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       output logic [31:0] rd, output logic er,
                       output int lat, output logic wide);
        int cyc;
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
        pc_m[k] = 32'h100 + a;
        @(posedge clk);
        @(negedge clk);
        req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '1;
        cyc = 1;
        while (ready[k] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        rd = rdata[k]; er = err[k]; lat = (ready[k] === 1'b1) ? cyc : -1;
        @(negedge clk);
        wide = ready[k];
        chk("rdata_hold", rdata[k], rd);
    endtask

    logic [31:0] rd;
    logic        er;
    logic        wide;
    int          lat;
    int          first;
    int          second;
    int          pulses;

    initial begin
        ncmp = 0; nfail = 0;
        reset = 1'b0; req = '0; we = '0;
        for (int k = 0; k < 3; k++) begin
            addr[k] = '0; be[k] = '0; wdata[k] = '0; pc_m[k] = '0;
        end

        tbl[0]  = '{1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        tbl[1]  = '{1'b0, 32'h10,       4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h10,       4'h5, 32'h11223344, 32'hDE22BE44, 1'b0};
        tbl[3]  = '{1'b0, 32'h10,       4'h3, 32'h0,        32'hDE22BE44, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,        4'hF, 32'h0,        32'h0,        1'b0};
        tbl[5]  = '{1'b1, 32'h0,        4'hF, 32'h01020304, 32'h01020304, 1'b0};
        tbl[6]  = '{1'b1, 32'h1000,     4'hF, 32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 32'h1000,     4'hF, 32'h0,        32'h0,        1'b1};
        tbl[8]  = '{1'b0, 32'h0,        4'hF, 32'h0,        32'h01020304, 1'b0};
        tbl[9]  = '{1'b1, 32'h3,        4'h8, 32'hAA55AA55, 32'hAA020304, 1'b0};
        tbl[10] = '{1'b1, 32'hFFC,      4'hF, 32'h12345678, 32'h12345678, 1'b0};
        tbl[11] = '{1'b0, 32'hFFE,      4'h0, 32'h0,        32'h12345678, 1'b0};
        tbl[12] = '{1'b1, 32'h10,       4'h0, 32'h99999999, 32'hDE22BE44, 1'b0};
        tbl[13] = '{1'b0, 32'h10,       4'h0, 32'h0,        32'hDE22BE44, 1'b0};
        tbl[14] = '{1'b0, 32'hFFFFFFFC, 4'hF, 32'h0,        32'h0,        1'b1};

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            txn(0, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata,
                rd, er, lat, wide);
            chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'd4);
            chk($sformatf("v%0d_width", i), 32'(wide), 32'd0);
        end

        txn(1, 1'b1, 32'h40, 4'hF, 32'hA5A5A5A5, rd, er, lat, wide);
        chk("w0_rdata", rd, 32'hA5A5A5A5);
        chk("w0_lat", 32'(lat), 32'd2);
        chk("w0_width", 32'(wide), 32'd0);
        txn(2, 1'b1, 32'h44, 4'h6, 32'h00BEEF00, rd, er, lat, wide);
        chk("w15_rdata", rd, 32'h00BEEF00);
        chk("w15_lat", 32'(lat), 32'd17);
        chk("w15_width", 32'(wide), 32'd0);
        txn(2, 1'b0, 32'h100, 4'hF, 32'h0, rd, er, lat, wide);
        chk("w15_oor_err", 32'(er), 32'd1);

        // Reset pulse while instance 0 is BUSY on a store.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20;
        be[0] = 4'hF; wdata[0] = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0; we[0] = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ready[0] === 1'b1) pulses++;
        end
        chk("rst_busy_noready", 32'(pulses), 32'd0);
        txn(0, 1'b0, 32'h20, 4'hF, 32'h0, rd, er, lat, wide);
        chk("rst_busy_nowrite", rd, 32'h0);
        txn(0, 1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat, wide);
        chk("rst_cleared", rd, 32'h0);

        txn(0, 1'b1, 32'h30, 4'hF, 32'h5EED5EED, rd, er, lat, wide);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h30;
        first = -1; second = -1;
        @(posedge clk);
        for (int c = 1; c < 30 && second < 0; c++) begin
            @(negedge clk);
            if (ready[0] === 1'b1) begin
                if (first < 0) begin
                    first = c;
                    chk("b2b_rd1", rdata[0], 32'h5EED5EED);
                end else begin
                    second = c;
                    req[0] = 1'b0;
                    chk("b2b_rd2", rdata[0], 32'h5EED5EED);
                end
            end
        end
        chk("b2b_first", 32'(first), 32'd4);
        chk("b2b_gap", 32'(second - first), 32'd5);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready[0] === 1'b1) pulses++;
        end
        chk("b2b_no_third", 32'(pulses), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
